// File: rtl/i8088_bus_cycle_ctrl.sv
// i8088_bus_cycle_ctrl
// Peripheral-side bus-cycle controller for the 8088 minimum-mode bus.
// Latches the multiplexed address on ALE, decodes one memory window and one
// I/O window into chip selects, inserts programmable wait states by pulling
// READY low, and sequences OE / WE for the attached peripheral.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined   : a cycle that sits in ADDR for TIMEOUT cycles after the ALE
//               sample without a strobe is abandoned with an ERR pulse.
//   Undefined : ADDR waits indefinitely and no timeout counter exists.
//
// Ports:
//   CLK      in   bus clock, all state on the rising edge
//   RESET    in   asynchronous active-high reset
//   AD[7:0]  in   multiplexed low address / data (address phase only)
//   A[11:0]  in   upper address A19:A8
//   ALE      in   address latch enable, active high
//   IOM      in   1 = I/O cycle, 0 = memory cycle
//   RD, WR   in   active-low read / write strobes
//   Address  out  latched 20-bit address
//   MEM_CS   out  memory window selected
//   IO_CS    out  I/O window selected
//   READY    out  to processor, 0 inserts a wait state
//   OE       out  peripheral may drive data
//   WE       out  one-cycle write strobe to peripheral
//   BUSY     out  controller not idle
//   ERR      out  one-cycle pulse on protocol error or timeout
module i8088_bus_cycle_ctrl #(
  parameter logic [19:0] MEM_BASE      = 20'h00000,
  parameter int          MEM_SIZE_LOG2 = 19,
  parameter logic [19:0] IO_BASE       = 20'h0FF00,
  parameter int          IO_SIZE_LOG2  = 8,
  parameter int          MEM_WAIT      = 0,
  parameter int          IO_WAIT       = 2,
  parameter int          TIMEOUT       = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  AD,
  input  logic [11:0] A,
  input  logic        ALE,
  input  logic        IOM,
  input  logic        RD,
  input  logic        WR,
  output logic [19:0] Address,
  output logic        MEM_CS,
  output logic        IO_CS,
  output logic        READY,
  output logic        OE,
  output logic        WE,
  output logic        BUSY,
  output logic        ERR
);

  // Reject parameter values the counters and decoders cannot represent.
  if (MEM_WAIT < 0 || MEM_WAIT > 15 || IO_WAIT < 0 || IO_WAIT > 15 ||
      TIMEOUT < 1 || MEM_SIZE_LOG2 > 20 || IO_SIZE_LOG2 > 16) begin : g_bad_params
    $error("i8088_bus_cycle_ctrl: parameter out of range");
  end

  localparam logic [3:0] MEM_N = 4'(MEM_WAIT);
  localparam logic [3:0] IO_N  = 4'(IO_WAIT);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, ACCESS, DONE} state_t;

  state_t      state, next_state;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic        is_write, is_write_next;
  logic        granted, granted_next;
  logic        err_q, err_next;
  logic        mem_hit, io_hit;
  logic [19:0] bus_addr;
  logic        mem_match, io_match;
  logic        strobe, both_strobes, released, timed_out;
  logic [3:0]  wait_sel;

  assign bus_addr = {A, AD};

  // Window compare on the bits above the window size; the I/O decode only
  // looks at the low 16 address bits.
  assign mem_match = !IOM && ((bus_addr >> MEM_SIZE_LOG2) == (MEM_BASE >> MEM_SIZE_LOG2));
  assign io_match  = IOM && (({4'h0, bus_addr[15:0]} >> IO_SIZE_LOG2) ==
                             ({4'h0, IO_BASE[15:0]} >> IO_SIZE_LOG2));

  assign strobe       = !RD || !WR;
  assign both_strobes = !RD && !WR;
  assign released     = RD && WR;
  assign wait_sel     = mem_hit ? MEM_N : IO_N;

`ifdef BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Counts edges spent in ADDR since the ALE sample; restarts on every ALE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      tmo_cnt <= '0;
    else if (ALE)
      tmo_cnt <= '0;
    else if (state == ADDR && !timed_out)
      tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign timed_out = (tmo_cnt == 16'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  // State and cycle bookkeeping; the address and decode result only change
  // on an ALE sample.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
      is_write <= 1'b0;
      granted  <= 1'b0;
      err_q    <= 1'b0;
      Address  <= '0;
      mem_hit  <= 1'b0;
      io_hit   <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      is_write <= is_write_next;
      granted  <= granted_next;
      err_q    <= err_next;
      if (ALE) begin
        Address <= bus_addr;
        mem_hit <= mem_match;
        io_hit  <= io_match;
      end
    end
  end

  // Next-state and output decode. ALE overrides everything so a new address
  // phase always abandons whatever cycle was in progress.
  always_comb begin
    next_state    = state;
    wait_cnt_next = wait_cnt;
    is_write_next = is_write;
    granted_next  = granted;
    err_next      = 1'b0;

    if (ALE) begin
      next_state    = ADDR;
      wait_cnt_next = '0;
      is_write_next = 1'b0;
      granted_next  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          if (both_strobes) begin
            err_next   = 1'b1;
            next_state = DONE;
          end else if (strobe) begin
            is_write_next = !WR;
            if (!(mem_hit || io_hit)) begin
              next_state = DONE;
            end else if (wait_sel == 4'd0) begin
              next_state   = ACCESS;
              granted_next = 1'b1;
            end else begin
              next_state    = WAIT;
              wait_cnt_next = wait_sel;
            end
          end else if (timed_out) begin
            err_next   = 1'b1;
            next_state = IDLE;
          end
        end
        WAIT: begin
          // A strobe that disappears mid-wait means the processor gave up.
          if (released) begin
            err_next      = 1'b1;
            next_state    = IDLE;
            wait_cnt_next = '0;
          end else if (wait_cnt <= 4'd1) begin
            next_state    = ACCESS;
            wait_cnt_next = '0;
            granted_next  = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt - 4'd1;
          end
        end
        ACCESS: next_state = DONE;
        DONE: begin
          if (released) begin
            next_state   = IDLE;
            granted_next = 1'b0;
          end
        end
        default: next_state = IDLE;
      endcase
    end

    READY  = (state != WAIT);
    BUSY   = (state != IDLE);
    MEM_CS = mem_hit && (state != IDLE);
    IO_CS  = io_hit && (state != IDLE);
    WE     = (state == ACCESS) && is_write;
    OE     = granted && !is_write && (state == ACCESS || state == DONE);
    ERR    = err_q;
  end

endmodule
